// File: rtl/led_blink_pkg.sv
// led_blink_pkg
//   Shared definitions for the multi-channel LED blinker: the mode field
//   width, the mode encodings and a helper that says whether a mode
//   advances its channel counter on prescaler ticks.
package led_blink_pkg;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'd0;
    localparam mode_t MODE_ON      = 2'd1;
    localparam mode_t MODE_BLINK   = 2'd2;
    localparam mode_t MODE_ONESHOT = 2'd3;

    // Only BLINK and ONESHOT consume ticks; OFF and ON keep their counter at 0.
    function automatic logic is_counting(mode_t m);
        return (m == MODE_BLINK) || (m == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/led_blink_chan.sv
// led_blink_chan
//   One LED channel: mode, half-period, tick counter, LED bit and done pulse.
//   Ports:
//     clk_i, rst_i   clock, asynchronous active-high reset
//     tick_i         shared prescaler tick (one clock wide)
//     sync_i         phase realign: counter to 0, relight counting modes
//     wr_en_i        decoded config write for this channel
//     mode_i/half_i  config payload (half of 0 is stored as 1)
//     led_o          registered LED drive
//     done_o         one-cycle pulse when a ONESHOT expires
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             sync_i,
    input  logic             wr_en_i,
    input  mode_t            mode_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             led_o,
    output logic             done_o
);

    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             led_q,  led_d;
    logic             done_q, done_d;

    // Priority: write, then sync, then tick. A write or sync on the same
    // edge as a tick discards that tick for this channel.
    always_comb begin
        mode_d = mode_q;
        half_d = half_q;
        cnt_d  = cnt_q;
        led_d  = led_q;
        done_d = 1'b0;
        if (wr_en_i) begin
            mode_d = mode_i;
            half_d = (half_i == '0) ? CNT_W'(1) : half_i;
            cnt_d  = '0;
            led_d  = (mode_i != MODE_OFF);
        end else if (sync_i) begin
            cnt_d = '0;
            if (is_counting(mode_q))
                led_d = 1'b1;
        end else if (tick_i && is_counting(mode_q)) begin
            // half_q is never 0, so half_q-1 cannot wrap.
            if (cnt_q == half_q - CNT_W'(1)) begin
                cnt_d = '0;
                if (mode_q == MODE_BLINK) begin
                    led_d = ~led_q;
                end else begin
                    led_d  = 1'b0;
                    mode_d = MODE_OFF;
                    done_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q <= MODE_OFF;
            half_q <= CNT_W'(1);
            cnt_q  <= '0;
            led_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            half_q <= half_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            done_q <= done_d;
        end
    end

    assign led_o  = led_q;
    assign done_o = done_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl
//   Multi-channel run-time programmable LED blinker. A shared prescaler
//   produces a tick every PRESCALE clocks; each channel blinks, holds or
//   fires a one-shot according to its own mode and half-period.
//   Ports:
//     i_Clk, i_Rst   clock, asynchronous active-high reset
//     i_Cfg_Wr       config write strobe (writes to i_Cfg_Ch >= NUM_CH ignored)
//     i_Cfg_Ch       target channel
//     i_Cfg_Mode     0 OFF, 1 ON, 2 BLINK, 3 ONESHOT
//     i_Cfg_Half     half-period in ticks (0 treated as 1)
//     i_Sync         realign prescaler and all channel phases
//     o_LED          registered LED drive, one bit per channel
//     o_Done         ONESHOT completion pulses, one bit per channel
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 12500,
    parameter int CH_W     = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Cfg_Wr,
    input  logic [CH_W-1:0]   i_Cfg_Ch,
    input  logic [1:0]        i_Cfg_Mode,
    input  logic [CNT_W-1:0]  i_Cfg_Half,
    input  logic              i_Sync,
    output logic [NUM_CH-1:0] o_LED,
    output logic [NUM_CH-1:0] o_Done
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] pre_q, pre_d;
    logic            tick;

    // With PRESCALE=1 the counter sits at 0 and tick is permanently high.
    assign tick = (pre_q == PS_W'(PRESCALE - 1));

    always_comb begin
        pre_d = pre_q + PS_W'(1);
        if (i_Sync || tick)
            pre_d = '0;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            pre_q <= '0;
        else
            pre_q <= pre_d;
    end

    // A tick on a sync edge is dropped: the prescaler restarts and the
    // channels see sync, which outranks tick.
    logic [NUM_CH-1:0] wr_en;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign wr_en[c] = i_Cfg_Wr && (i_Cfg_Ch == CH_W'(c));

        led_blink_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_i   (i_Clk),
            .rst_i   (i_Rst),
            .tick_i  (tick),
            .sync_i  (i_Sync),
            .wr_en_i (wr_en[c]),
            .mode_i  (mode_t'(i_Cfg_Mode)),
            .half_i  (i_Cfg_Half),
            .led_o   (o_LED[c]),
            .done_o  (o_Done[c])
        );
    end

endmodule
